// File: rtl/cu_pkg.sv
// cu_pkg: shared types and encodings for the multi-cycle control unit.
// Holds the state encodings, opcode constants, the ExtSel/RegDst/PCSrc/ALUOp
// encodings and small opcode-classification helpers.
// Optional feature macro: CU_HALT_EN (adds a HALT state; internal state widens to 4 bits).
package cu_pkg;

`ifdef CU_HALT_EN
    localparam int unsigned STATE_W = 4;
`else
    localparam int unsigned STATE_W = 3;
`endif

    typedef enum logic [STATE_W-1:0] {
        S_IF    = STATE_W'(0),
        S_ID    = STATE_W'(1),
        S_EXE_M = STATE_W'(2),
        S_MEM   = STATE_W'(3),
        S_WB_M  = STATE_W'(4),
        S_EXE_B = STATE_W'(5),
        S_EXE_A = STATE_W'(6),
`ifdef CU_HALT_EN
        S_HALT  = STATE_W'(8),
`endif
        S_WB_A  = STATE_W'(7)
    } state_t;

    // Opcodes (IR[31:26])
    localparam logic [5:0] OP_ADD   = 6'b000000;
    localparam logic [5:0] OP_SUB   = 6'b000001;
    localparam logic [5:0] OP_ADDIU = 6'b000010;
    localparam logic [5:0] OP_AND   = 6'b010000;
    localparam logic [5:0] OP_ANDI  = 6'b010001;
    localparam logic [5:0] OP_ORI   = 6'b010010;
    localparam logic [5:0] OP_XOR   = 6'b010011;
    localparam logic [5:0] OP_SLL   = 6'b011000;
    localparam logic [5:0] OP_SLTI  = 6'b100110;
    localparam logic [5:0] OP_SW    = 6'b110000;
    localparam logic [5:0] OP_LW    = 6'b110001;
    localparam logic [5:0] OP_BEQ   = 6'b110100;
    localparam logic [5:0] OP_BNE   = 6'b110101;
    localparam logic [5:0] OP_BLTZ  = 6'b110110;
    localparam logic [5:0] OP_J     = 6'b111000;
    localparam logic [5:0] OP_JR    = 6'b111001;
    localparam logic [5:0] OP_JAL   = 6'b111010;
    localparam logic [5:0] OP_HALT  = 6'b111111;

    localparam logic [1:0] EXT_SA   = 2'b00;
    localparam logic [1:0] EXT_ZERO = 2'b01;
    localparam logic [1:0] EXT_SIGN = 2'b10;

    localparam logic [1:0] REGDST_R31 = 2'b00;
    localparam logic [1:0] REGDST_RT  = 2'b01;
    localparam logic [1:0] REGDST_RD  = 2'b10;

    localparam logic [1:0] PCSRC_NEXT   = 2'b00;
    localparam logic [1:0] PCSRC_BRANCH = 2'b01;
    localparam logic [1:0] PCSRC_JR     = 2'b10;
    localparam logic [1:0] PCSRC_JUMP   = 2'b11;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_SLL = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_AND = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b110;
    localparam logic [2:0] ALU_XOR = 3'b111;

    function automatic logic is_alu(input logic [5:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_ADDIU, OP_AND, OP_ANDI,
            OP_ORI, OP_XOR, OP_SLL, OP_SLTI: return 1'b1;
            default:                         return 1'b0;
        endcase
    endfunction

    // ALU ops whose second operand is the extended immediate (write to rt)
    function automatic logic is_imm(input logic [5:0] op);
        case (op)
            OP_ADDIU, OP_ANDI, OP_ORI, OP_SLTI: return 1'b1;
            default:                            return 1'b0;
        endcase
    endfunction

    function automatic logic is_branch(input logic [5:0] op);
        return (op == OP_BEQ) || (op == OP_BNE) || (op == OP_BLTZ);
    endfunction

    function automatic logic is_mem(input logic [5:0] op);
        return (op == OP_SW) || (op == OP_LW);
    endfunction

    function automatic logic [2:0] alu_op_of(input logic [5:0] op);
        case (op)
            OP_SUB:          return ALU_SUB;
            OP_AND, OP_ANDI: return ALU_AND;
            OP_ORI:          return ALU_OR;
            OP_XOR:          return ALU_XOR;
            OP_SLL:          return ALU_SLL;
            OP_SLTI:         return ALU_SLT;
            default:         return ALU_ADD;
        endcase
    endfunction

    function automatic logic [1:0] ext_sel_of(input logic [5:0] op);
        case (op)
            OP_SLL:          return EXT_SA;
            OP_ANDI, OP_ORI: return EXT_ZERO;
            default:         return EXT_SIGN;
        endcase
    endfunction

endpackage

// File: rtl/cu_decode.sv
// cu_decode: purely combinational datapath-control decoder.
// Inputs : rst (forces write enables low), state, opcode, zero, sign.
// Outputs: PCWre, IRWre, InsMemRW, RegDst, RegWre, WrRegDSrc, ALUSrcA,
//          ALUSrcB, ALUOp, DBDataSrc, mRD, mWR, ExtSel, PCSrc.
// Optional feature macro: CU_HALT_EN (halt in ID does not update the PC).
module cu_decode
    import cu_pkg::*;
(
    input  logic       rst,
    input  state_t     state,
    input  logic [5:0] opcode,
    input  logic       zero,
    input  logic       sign,
    output logic       PCWre,
    output logic       IRWre,
    output logic       InsMemRW,
    output logic [1:0] RegDst,
    output logic       RegWre,
    output logic       WrRegDSrc,
    output logic       ALUSrcA,
    output logic       ALUSrcB,
    output logic [2:0] ALUOp,
    output logic       DBDataSrc,
    output logic       mRD,
    output logic       mWR,
    output logic [1:0] ExtSel,
    output logic [1:0] PCSrc
);

    logic pc_wre;
    logic ir_wre;
    logic reg_wre;
    logic m_wr;
    logic taken;

    assign taken = ((opcode == OP_BEQ)  &&  zero) ||
                   ((opcode == OP_BNE)  && !zero) ||
                   ((opcode == OP_BLTZ) &&  sign);

    // Per-state control decode; everything not named for a state stays 0
    always_comb begin
        pc_wre    = 1'b0;
        ir_wre    = 1'b0;
        reg_wre   = 1'b0;
        m_wr      = 1'b0;
        InsMemRW  = 1'b0;
        RegDst    = REGDST_R31;
        WrRegDSrc = 1'b0;
        ALUSrcA   = 1'b0;
        ALUSrcB   = 1'b0;
        ALUOp     = ALU_ADD;
        DBDataSrc = 1'b0;
        mRD       = 1'b0;
        PCSrc     = PCSRC_NEXT;
        ExtSel    = ext_sel_of(opcode);
        case (state)
            S_IF: begin
                ir_wre   = 1'b1;
                InsMemRW = 1'b1;
            end
            S_ID: begin
                // Jumps and illegal opcodes finish here
                if (!(is_alu(opcode) || is_branch(opcode) || is_mem(opcode))) begin
`ifdef CU_HALT_EN
                    pc_wre = (opcode != OP_HALT);
`else
                    pc_wre = 1'b1;
`endif
                    case (opcode)
                        OP_JR: PCSrc = PCSRC_JR;
                        OP_J:  PCSrc = PCSRC_JUMP;
                        OP_JAL: begin
                            PCSrc     = PCSRC_JUMP;
                            reg_wre   = 1'b1;
                            RegDst    = REGDST_R31;
                            WrRegDSrc = 1'b0;
                        end
                        default: PCSrc = PCSRC_NEXT;
                    endcase
                end
            end
            S_EXE_A: begin
                ALUOp   = alu_op_of(opcode);
                ALUSrcA = (opcode == OP_SLL);
                ALUSrcB = is_imm(opcode);
            end
            S_WB_A: begin
                reg_wre   = 1'b1;
                pc_wre    = 1'b1;
                WrRegDSrc = 1'b1;
                RegDst    = is_imm(opcode) ? REGDST_RT : REGDST_RD;
            end
            S_EXE_B: begin
                ALUOp  = ALU_SUB;
                pc_wre = 1'b1;
                PCSrc  = taken ? PCSRC_BRANCH : PCSRC_NEXT;
            end
            S_EXE_M: begin
                ALUOp   = ALU_ADD;
                ALUSrcB = 1'b1;
            end
            S_MEM: begin
                if (opcode == OP_SW) begin
                    m_wr   = 1'b1;
                    pc_wre = 1'b1;
                end else begin
                    mRD = 1'b1;
                end
            end
            S_WB_M: begin
                DBDataSrc = 1'b1;
                reg_wre   = 1'b1;
                RegDst    = REGDST_RT;
                WrRegDSrc = 1'b1;
                pc_wre    = 1'b1;
            end
            default: ;
        endcase
    end

    // Reset overrides state-driven write enables immediately
    assign PCWre  = pc_wre  & ~rst;
    assign IRWre  = ir_wre  & ~rst;
    assign RegWre = reg_wre & ~rst;
    assign mWR    = m_wr    & ~rst;

endmodule

// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit: multi-cycle CPU control FSM
// (IF/ID/EXE/MEM/WB). Holds the state register and next-state logic;
// the control outputs come from the combinational cu_decode instance.
// Inputs : CLK, RST (async, active-high), opcode[5:0], zero, sign.
// Outputs: state[2:0] plus all datapath control lines.
// Optional feature macro: CU_HALT_EN (halt opcode parks the FSM in HALT until RST;
//          the state port then reads 3'b000).
module multicycle_control_unit
    import cu_pkg::*;
(
    input  logic       CLK,
    input  logic       RST,
    input  logic [5:0] opcode,
    input  logic       zero,
    input  logic       sign,
    output logic [2:0] state,
    output logic       PCWre,
    output logic       IRWre,
    output logic       InsMemRW,
    output logic [1:0] RegDst,
    output logic       RegWre,
    output logic       WrRegDSrc,
    output logic       ALUSrcA,
    output logic       ALUSrcB,
    output logic [2:0] ALUOp,
    output logic       DBDataSrc,
    output logic       mRD,
    output logic       mWR,
    output logic [1:0] ExtSel,
    output logic [1:0] PCSrc
);

    state_t state_q;
    state_t state_d;

    // State register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state_q <= S_IF;
        else     state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IF: state_d = S_ID;
            S_ID: begin
                if (is_alu(opcode))         state_d = S_EXE_A;
                else if (is_branch(opcode)) state_d = S_EXE_B;
                else if (is_mem(opcode))    state_d = S_EXE_M;
`ifdef CU_HALT_EN
                else if (opcode == OP_HALT) state_d = S_HALT;
`endif
                else                        state_d = S_IF;
            end
            S_EXE_A: state_d = S_WB_A;
            S_WB_A:  state_d = S_IF;
            S_EXE_B: state_d = S_IF;
            S_EXE_M: state_d = S_MEM;
            S_MEM:   state_d = (opcode == OP_LW) ? S_WB_M : S_IF;
            S_WB_M:  state_d = S_IF;
`ifdef CU_HALT_EN
            S_HALT:  state_d = S_HALT;
`endif
            default: state_d = S_IF;
        endcase
    end

    // HALT encodes as 4'b1000, so the visible low bits read as 000
    assign state = state_q[2:0];

    cu_decode u_decode (
        .rst       (RST),
        .state     (state_q),
        .opcode    (opcode),
        .zero      (zero),
        .sign      (sign),
        .PCWre     (PCWre),
        .IRWre     (IRWre),
        .InsMemRW  (InsMemRW),
        .RegDst    (RegDst),
        .RegWre    (RegWre),
        .WrRegDSrc (WrRegDSrc),
        .ALUSrcA   (ALUSrcA),
        .ALUSrcB   (ALUSrcB),
        .ALUOp     (ALUOp),
        .DBDataSrc (DBDataSrc),
        .mRD       (mRD),
        .mWR       (mWR),
        .ExtSel    (ExtSel),
        .PCSrc     (PCSrc)
    );

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed self-checking bench for multicycle_control_unit.
module tb_multicycle_control_unit;

    logic       CLK = 1'b0;
    logic       RST;
    logic [5:0] opcode;
    logic       zero;
    logic       sign;
    logic [2:0] state;
    logic       PCWre, IRWre, InsMemRW, RegWre, WrRegDSrc;
    logic       ALUSrcA, ALUSrcB, DBDataSrc, mRD, mWR;
    logic [1:0] RegDst, ExtSel, PCSrc;
    logic [2:0] ALUOp;

    int passed = 0;
    int total  = 0;

    multicycle_control_unit dut (
        .CLK(CLK), .RST(RST), .opcode(opcode), .zero(zero), .sign(sign),
        .state(state), .PCWre(PCWre), .IRWre(IRWre), .InsMemRW(InsMemRW),
        .RegDst(RegDst), .RegWre(RegWre), .WrRegDSrc(WrRegDSrc),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
        .DBDataSrc(DBDataSrc), .mRD(mRD), .mWR(mWR), .ExtSel(ExtSel),
        .PCSrc(PCSrc)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Advance one cycle and sample just after the rising edge
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        RST = 1'b1; opcode = 6'b000010; zero = 1'b0; sign = 1'b0;
        #2;
        chk("rst_state",  32'(state),    0);
        chk("rst_irwre",  32'(IRWre),    0);
        chk("rst_pcwre",  32'(PCWre),    0);
        chk("rst_regwre", 32'(RegWre),   0);
        chk("rst_insmem", 32'(InsMemRW), 1);
        @(negedge CLK);
        RST = 1'b0;
        #1;
        chk("if_state", 32'(state), 0);
        chk("if_irwre", 32'(IRWre), 1);

        // addiu
        tick(); chk("addiu_id", 32'(state), 1);
        chk("addiu_id_pcwre", 32'(PCWre), 0);
        chk("addiu_id_irwre", 32'(IRWre), 0);
        tick(); chk("addiu_exea", 32'(state), 6);
        chk("addiu_extsel", 32'(ExtSel), 2);
        chk("addiu_alusrcb", 32'(ALUSrcB), 1);
        chk("addiu_aluop", 32'(ALUOp), 0);
        chk("addiu_exea_regwre", 32'(RegWre), 0);
        chk("addiu_exea_pcwre", 32'(PCWre), 0);
        tick(); chk("addiu_wba", 32'(state), 7);
        chk("addiu_wba_regwre", 32'(RegWre), 1);
        chk("addiu_wba_regdst", 32'(RegDst), 1);
        chk("addiu_wba_pcwre", 32'(PCWre), 1);
        tick(); chk("addiu_if", 32'(state), 0);
        chk("addiu_if_pcwre", 32'(PCWre), 0);
        chk("addiu_if_regwre", 32'(RegWre), 0);

        // lw
        opcode = 6'b110001;
        tick(); chk("lw_id", 32'(state), 1);
        tick(); chk("lw_exem", 32'(state), 2);
        chk("lw_exem_alusrcb", 32'(ALUSrcB), 1);
        chk("lw_exem_mwr", 32'(mWR), 0);
        tick(); chk("lw_mem", 32'(state), 3);
        chk("lw_mem_mrd", 32'(mRD), 1);
        chk("lw_mem_mwr", 32'(mWR), 0);
        chk("lw_mem_pcwre", 32'(PCWre), 0);
        tick(); chk("lw_wbm", 32'(state), 4);
        chk("lw_wbm_dbsrc", 32'(DBDataSrc), 1);
        chk("lw_wbm_regwre", 32'(RegWre), 1);
        chk("lw_wbm_mwr", 32'(mWR), 0);
        chk("lw_wbm_pcwre", 32'(PCWre), 1);
        tick(); chk("lw_if", 32'(state), 0);

        // beq taken
        opcode = 6'b110100; zero = 1'b1;
        tick(); chk("beq1_id", 32'(state), 1);
        tick(); chk("beq1_exeb", 32'(state), 5);
        chk("beq1_pcsrc", 32'(PCSrc), 1);
        chk("beq1_aluop", 32'(ALUOp), 1);
        chk("beq1_pcwre", 32'(PCWre), 1);
        tick(); chk("beq1_if", 32'(state), 0);

        // beq not taken
        zero = 1'b0;
        tick(); chk("beq0_id", 32'(state), 1);
        tick(); chk("beq0_exeb", 32'(state), 5);
        chk("beq0_pcsrc", 32'(PCSrc), 0);
        chk("beq0_pcwre", 32'(PCWre), 1);
        tick(); chk("beq0_if", 32'(state), 0);

        // bltz taken on sign
        opcode = 6'b110110; sign = 1'b1;
        tick(); tick(); chk("bltz_pcsrc", 32'(PCSrc), 1);
        tick(); chk("bltz_if", 32'(state), 0);
        sign = 1'b0;

        // jal
        opcode = 6'b111010;
        tick(); chk("jal_id", 32'(state), 1);
        chk("jal_regwre", 32'(RegWre), 1);
        chk("jal_regdst", 32'(RegDst), 0);
        chk("jal_wrsrc", 32'(WrRegDSrc), 0);
        chk("jal_pcsrc", 32'(PCSrc), 3);
        chk("jal_pcwre", 32'(PCWre), 1);
        tick(); chk("jal_if", 32'(state), 0);

        // jr
        opcode = 6'b111001;
        tick(); chk("jr_pcsrc", 32'(PCSrc), 2);
        chk("jr_regwre", 32'(RegWre), 0);
        tick(); chk("jr_if", 32'(state), 0);

        // andi
        opcode = 6'b010001;
        tick(); tick(); chk("andi_exea", 32'(state), 6);
        chk("andi_extsel", 32'(ExtSel), 1);
        chk("andi_aluop", 32'(ALUOp), 4);
        tick(); chk("andi_regdst", 32'(RegDst), 1);
        tick();

        // sll
        opcode = 6'b011000;
        tick(); tick(); chk("sll_exea", 32'(state), 6);
        chk("sll_extsel", 32'(ExtSel), 0);
        chk("sll_alusrca", 32'(ALUSrcA), 1);
        chk("sll_alusrcb", 32'(ALUSrcB), 0);
        chk("sll_aluop", 32'(ALUOp), 2);
        tick(); chk("sll_regdst", 32'(RegDst), 2);
        tick(); chk("sll_if", 32'(state), 0);

        // illegal opcode: 2-cycle NOP
        opcode = 6'b101010;
        tick(); chk("ill_id", 32'(state), 1);
        chk("ill_pcsrc", 32'(PCSrc), 0);
        chk("ill_pcwre", 32'(PCWre), 1);
        chk("ill_regwre", 32'(RegWre), 0);
        tick(); chk("ill_if", 32'(state), 0);

        // sw aborted by reset in MEM
        opcode = 6'b110000;
        tick(); tick(); chk("sw_exem", 32'(state), 2);
        tick(); chk("sw_mem", 32'(state), 3);
        chk("sw_mem_mwr", 32'(mWR), 1);
        chk("sw_mem_pcwre", 32'(PCWre), 1);
        #2; RST = 1'b1;
        #1;
        chk("sw_rst_mwr", 32'(mWR), 0);
        chk("sw_rst_state", 32'(state), 0);
        chk("sw_rst_pcwre", 32'(PCWre), 0);
        @(negedge CLK);
        RST = 1'b0;
        opcode = 6'b111111;
        #1;
        chk("post_rst_irwre", 32'(IRWre), 1);

        // halt
        tick(); chk("halt_id", 32'(state), 1);
`ifdef CU_HALT_EN
        chk("halt_id_pcwre", 32'(PCWre), 0);
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("halt_state", 32'(state), 0);
            chk("halt_pcwre", 32'(PCWre), 0);
            chk("halt_irwre", 32'(IRWre), 0);
        end
`else
        chk("halt_id_pcwre", 32'(PCWre), 1);
        chk("halt_id_pcsrc", 32'(PCSrc), 0);
        tick(); chk("halt_if", 32'(state), 0);
        chk("halt_if_irwre", 32'(IRWre), 1);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/multicycle_control_unit.md
# multicycle_control_unit

Multi-cycle control state machine for the CPU datapath. Sequences each instruction through fetch/decode/execute/memory/write-back states and drives every datapath control line, including the 2-bit `ExtSel` consumed by the sign-extension stage that widens the instruction's 16-bit immediate field. Sits between the instruction register (opcode source) and the datapath muxes, register file, ALU, data memory and PC.

## Interface
- No parameters.
- `CLK` in 1: single system clock, rising edge.
- `RST` in 1: asynchronous, active-high reset.
- `opcode` in 6: IR[31:26], valid from ID onward.
- `zero` in 1: ALU result == 0.
- `sign` in 1: ALU result[31].
- `state` out 3: current state encoding.
- `PCWre` out 1: PC write enable.
- `IRWre` out 1: instruction register load.
- `InsMemRW` out 1: instruction memory read, 1 = read.
- `RegDst` out 2: write register, 00 = $31, 01 = rt, 10 = rd.
- `RegWre` out 1: register file write enable.
- `WrRegDSrc` out 1: write data, 0 = PC+4, 1 = DB.
- `ALUSrcA` out 1: 1 = zero-extended sa.
- `ALUSrcB` out 1: 1 = extended immediate.
- `ALUOp` out 3: 000 add, 001 sub, 010 sll (B<<A), 011 or, 100 and, 110 slt, 111 xor.
- `DBDataSrc` out 1: 0 = ALU, 1 = data memory.
- `mRD` out 1: data memory read.
- `mWR` out 1: data memory write.
- `ExtSel` out 2: 00 = sa, 01 = zero-extend, 10 = sign-extend.
- `PCSrc` out 2: 00 = PC+4, 01 = branch target, 10 = rs (jr), 11 = jump target.

## Operation
- States: IF=000, ID=001, EXE_M=010, MEM=011, WB_M=100, EXE_B=101, EXE_A=110, WB_A=111.
- Opcodes:
  - add 000000, sub 000001, addiu 000010
  - and 010000, andi 010001, ori 010010, xor 010011, sll 011000, slti 100110
  - sw 110000, lw 110001
  - beq 110100, bne 110101, bltz 110110
  - j 111000, jr 111001, jal 111010, halt 111111
- Transitions:
  - IF → ID.
  - ID → EXE_A for ALU ops, EXE_B for branches, EXE_M for sw/lw.
  - ID → IF for j/jr/jal and for illegal opcodes.
  - EXE_A → WB_A → IF.
  - EXE_B → IF.
  - EXE_M → MEM.
  - MEM → WB_M (lw) or IF (sw).
  - WB_M → IF.
- Outputs: combinational decode of (state, opcode, zero, sign). Every output not listed for a state is 0.
- IF: `IRWre`=1, `InsMemRW`=1.
- Final state of each instruction asserts `PCWre`=1. Final states are WB_A, EXE_B, MEM(sw), WB_M, and ID for jumps/illegal. The PC updates on the edge that enters IF.
- `PCSrc`:
  - 01 in EXE_B when taken: beq & zero, bne & !zero, bltz & sign.
  - 10 for jr, 11 for j/jal.
  - 00 otherwise, including illegal opcodes.
- jal in ID: `RegWre`=1, `RegDst`=00, `WrRegDSrc`=0.
- `ExtSel`: 00 for sll; 01 for andi/ori; 10 for all other opcodes, including default.
- `RegWre` is asserted only in WB_A, WB_M and jal-ID. `mWR` is asserted only in MEM for sw. `mRD` is asserted in MEM for lw.
- branch EXE_B: `ALUOp`=001 (sub). bltz compares rs against $0.
- slti: `ALUOp`=110. sll: `ALUSrcA`=1.

## Timing
- Latency in cycles: j/jr/jal/illegal 2, branches 3, ALU ops 4, sw 4, lw 5.
- `zero` and `sign` are sampled combinationally during EXE_B. They must be stable before the rising edge.
- RST high: state forced to IF immediately.
- RST high: `PCWre`, `IRWre`, `RegWre` and `mWR` are forced to 0 regardless of state. This applies mid-instruction too; an in-flight store or write-back is aborted.
- First rising edge after RST deasserts: IR loads and the FSM enters ID.

## Configuration
- `CU_HALT_EN` defined:
  - Adds a ninth state HALT=000 shadow; internal state width becomes 4, and the `state` port shows 3'b000 with a separate internal flag.
  - halt in ID → HALT. HALT holds with `PCWre`=0 and `IRWre`=0 until RST.
- `CU_HALT_EN` undefined: halt is treated as an illegal opcode (2-cycle NOP, PC+4).

## Structure
- Package `cu_pkg` holds:
  - state encodings
  - opcode constants
  - `ExtSel`, `RegDst`, `PCSrc` and `ALUOp` encodings
- Sub-module `cu_decode` holds the purely combinational output decoder.
- Top level keeps only the state register and the next-state logic.

## Test plan
- addiu (000010) from reset:
  - states IF, ID, EXE_A, WB_A, IF.
  - `ExtSel`=10 and `ALUSrcB`=1 in EXE_A.
  - `RegWre`=1 and `RegDst`=01 in WB_A only.
  - `PCWre` pulses once.
- lw (110001):
  - 5-cycle trace ending WB_M.
  - `mRD`=1 in MEM; `DBDataSrc`=1 and `RegWre`=1 in WB_M.
  - `mWR` never 1.
- beq with zero=1 → `PCSrc`=01 in EXE_B. Repeat with zero=0 → `PCSrc`=00. Both return to IF after 3 cycles.
- jal (111010): ID has `RegWre`=1, `RegDst`=00, `WrRegDSrc`=0, `PCSrc`=11, `PCWre`=1; next state IF.
- andi then sll: `ExtSel`=01 then 00. Opcode 101010 (illegal): 2-cycle NOP with `PCSrc`=00.
- RST asserted during sw MEM: `mWR` drops to 0 the same cycle and state becomes IF. With `CU_HALT_EN`, halt stays in HALT for 20 cycles with no `PCWre`.
